// File: rtl/controle_escrita_registradores.sv
// controle_escrita_registradores
// Write-back sequencer for the register bank write port. It takes requests
// from the memory-load path and the ALU path (the memory path has fixed
// priority), queues them in order, and issues at most one Reg_Write per cycle.
// It also reports whether a queried register still has a write in flight.
//
// Ports:
//   clock, reset                     : clock, async active-low reset
//   alu_valido/pronto/endereco/dados : ALU request handshake + payload
//   mem_valido/pronto/endereco/dados : load request handshake + payload
//   parar_escrita                    : holds the queue (no drain) while high
//   endereco_consulta_1/2            : hazard query addresses
//   pendente_1/2                     : queried register has a write in flight
//   Reg_Write, endereco_escrita,
//   escrever_dados                   : registered bank write port
//   ocupacao                         : current queue entry count
module controle_escrita_registradores #(
  parameter int PROFUNDIDADE  = 4,
  parameter int LARGURA_DADOS = 32,
  parameter int LARGURA_END   = 5
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             alu_valido,
  output logic                             alu_pronto,
  input  logic [LARGURA_END-1:0]           alu_endereco,
  input  logic [LARGURA_DADOS-1:0]         alu_dados,
  input  logic                             mem_valido,
  output logic                             mem_pronto,
  input  logic [LARGURA_END-1:0]           mem_endereco,
  input  logic [LARGURA_DADOS-1:0]         mem_dados,
  input  logic                             parar_escrita,
  input  logic [LARGURA_END-1:0]           endereco_consulta_1,
  input  logic [LARGURA_END-1:0]           endereco_consulta_2,
  output logic                             pendente_1,
  output logic                             pendente_2,
  output logic                             Reg_Write,
  output logic [LARGURA_END-1:0]           endereco_escrita,
  output logic [LARGURA_DADOS-1:0]         escrever_dados,
  output logic [$clog2(PROFUNDIDADE+1)-1:0] ocupacao
);

  localparam int PW = $clog2(PROFUNDIDADE);
  localparam int OW = $clog2(PROFUNDIDADE+1);

  typedef struct packed {
    logic [LARGURA_END-1:0]   ender;
    logic [LARGURA_DADOS-1:0] dados;
  } entrada_t;

  entrada_t                fila [PROFUNDIDADE];
  logic [PROFUNDIDADE-1:0] vld;            // per-slot occupancy, for the hazard compare
  logic [PW-1:0]           ptr_esc, ptr_lei;

  entrada_t entrada;
  logic     cheio, acc_mem, acc_alu, push, pop;

  // Ready uses the pre-edge count, so a full queue never accepts even when
  // a pop happens on the same edge.
  assign cheio      = (ocupacao == OW'(PROFUNDIDADE));
  assign mem_pronto = !cheio;
  assign alu_pronto = !cheio && !mem_valido;
  assign acc_mem    = mem_valido && mem_pronto;
  assign acc_alu    = alu_valido && alu_pronto;
  assign entrada    = acc_mem ? '{ender: mem_endereco, dados: mem_dados}
                              : '{ender: alu_endereco, dados: alu_dados};
  // Writes to register 0 are acknowledged but dropped.
  assign push       = (acc_mem || acc_alu) && (entrada.ender != '0);
  assign pop        = (ocupacao != '0) && !parar_escrita;

  always_ff @(posedge clock) begin
    if (push) fila[ptr_esc] <= entrada;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr_esc          <= '0;
      ptr_lei          <= '0;
      ocupacao         <= '0;
      vld              <= '0;
      Reg_Write        <= 1'b0;
      endereco_escrita <= '0;
      escrever_dados   <= '0;
    end else begin
      if (pop) begin
        vld[ptr_lei]     <= 1'b0;
        ptr_lei          <= ptr_lei + 1'b1;
        Reg_Write        <= 1'b1;
        endereco_escrita <= fila[ptr_lei].ender;
        escrever_dados   <= fila[ptr_lei].dados;
      end else begin
        Reg_Write        <= 1'b0;
      end
      // Push and pop never target the same slot: push implies not full.
      if (push) begin
        vld[ptr_esc] <= 1'b1;
        ptr_esc      <= ptr_esc + 1'b1;
      end
      case ({push, pop})
        2'b10:   ocupacao <= ocupacao + 1'b1;
        2'b01:   ocupacao <= ocupacao - 1'b1;
        default: ocupacao <= ocupacao;
      endcase
    end
  end

  // Hazard compare: every occupied slot plus the write currently on the port.
  logic [PROFUNDIDADE-1:0] hit1, hit2;
  for (genvar i = 0; i < PROFUNDIDADE; i++) begin : g_cmp
    assign hit1[i] = vld[i] && (fila[i].ender == endereco_consulta_1);
    assign hit2[i] = vld[i] && (fila[i].ender == endereco_consulta_2);
  end

  assign pendente_1 = (endereco_consulta_1 != '0) &&
                      ((|hit1) || (Reg_Write && (endereco_escrita == endereco_consulta_1)));
  assign pendente_2 = (endereco_consulta_2 != '0) &&
                      ((|hit2) || (Reg_Write && (endereco_escrita == endereco_consulta_2)));

endmodule
